// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: shared op encodings, default latencies and FSM states for the mul/div sequencer
package muldiv_ctrl_pkg;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdState_t;

    function automatic logic isDiv(input logic [1:0] op);
        return op == MD_DIV || op == MD_DIVU;
    endfunction

endpackage

// File: rtl/muldiv_arith.sv
// muldiv_arith: combinational mult/multu/div/divu producing {hi,lo} and a divide-by-zero flag
module muldiv_arith
    import muldiv_ctrl_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic [63:0] result,
    output logic        div0
);

    logic [63:0] sProd, uProd;
    logic [31:0] safeB, uQuot, uRem;
    logic signed [31:0] sQuot, sRem;

    // A zero divisor is replaced by 1 so the dividers never produce X; the result is discarded anyway.
    assign div0  = isDiv(op) && srcB == '0;
    assign safeB = (srcB == '0) ? 32'd1 : srcB;

    // Sign-extending to 64 bits makes an unsigned multiply yield the signed product's low 64 bits.
    assign sProd = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
    assign uProd = {32'd0, srcA} * {32'd0, srcB};

    assign sQuot = $signed(srcA) / $signed(safeB);
    assign sRem  = $signed(srcA) % $signed(safeB);
    assign uQuot = srcA / safeB;
    assign uRem  = srcA % safeB;

    always_comb begin
        result = (op == MD_MULT)  ? sProd :
                 (op == MD_MULTU) ? uProd :
                 (op == MD_DIV)   ? {sRem, sQuot} :
                                    {uRem, uQuot};
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences the multiply/divide unit, owns HI/LO, and requests D-stage stalls while busy
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        md_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    mdState_t    state, nextState;
    logic [CW-1:0] cnt;
    logic [63:0] pending, result;
    logic        pendCommit, div0, lastCycle;

    muldiv_arith uArith (
        .op    (op),
        .srcA  (srcA),
        .srcB  (srcB),
        .result(result),
        .div0  (div0)
    );

    assign lastCycle = cnt == CW'(1);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        if (state == S_IDLE) nextState = start ? S_BUSY : S_IDLE;
        else                 nextState = lastCycle ? S_IDLE : S_BUSY;
    end

    always_comb begin
        busy     = state == S_BUSY;
        stall_md = md_D && (busy || start);
    end

    // mt writes only land in IDLE and lose to a simultaneous start; HI/LO otherwise change only at commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            pending    <= '0;
            pendCommit <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else if (state == S_IDLE) begin
            if (start) begin
                pending    <= result;
                pendCommit <= !div0;
                cnt        <= isDiv(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end else begin
                if (mthi) hi <= wdata;
                if (mtlo) lo <= wdata;
            end
        end else begin
            cnt <= cnt - CW'(1);
            if (lastCycle && pendCommit) begin
                hi <= pending[63:32];
                lo <= pending[31:0];
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed stimulus with a scoreboard queue checked by a completion monitor
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } expOp_t;

    logic        clk = 1'b0;
    logic        reset, start, mthi, mtlo, md_D;
    logic [1:0]  op;
    logic [31:0] srcA, srcB, wdata;
    logic        busy, stall_md;
    logic [31:0] hi, lo;

    int     checks = 0;
    int     errors = 0;
    expOp_t sb[$];

    muldiv_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .srcA    (srcA),
        .srcB    (srcB),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .wdata   (wdata),
        .md_D    (md_D),
        .busy    (busy),
        .stall_md(stall_md),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a busy 1->0 transition is a completion; compare busy length and HI/LO with the queue head.
    int   busyCnt = 0;
    logic prevBusy = 1'b0;
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            busyCnt++;
        end else if (prevBusy) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected completion: hi %h lo %h with empty scoreboard", hi, lo);
            end else begin
                expOp_t e;
                e = sb.pop_front();
                chk({e.name, " busy cycles"}, busyCnt, e.cyc);
                chk({e.name, " hi"}, hi, e.hi);
                chk({e.name, " lo"}, lo, e.lo);
            end
            busyCnt = 0;
        end
        prevBusy = busy;
    end

    task automatic pushExp(input logic [31:0] eh, input logic [31:0] el, input int c, input string n);
        expOp_t e;
        e.hi = eh;
        e.lo = el;
        e.cyc = c;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic startOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eh, input logic [31:0] el, input int c, input string n);
        start = 1'b1;
        op = o;
        srcA = a;
        srcB = b;
        pushExp(eh, el, c, n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL wait idle: busy still %b after %0d cycles", busy, n);
        end
    endtask

    task automatic mtWrite(input logic h, input logic l, input logic [31:0] d);
        mthi = h;
        mtlo = l;
        wdata = d;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; md_D = 1'b0;
        op = '0; srcA = '0; srcB = '0; wdata = '0;
        repeat (3) @(negedge clk);
        md_D = 1'b1;
        #1;
        chk("reset busy", busy, 0);
        chk("reset stall", stall_md, 0);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        reset = 1'b0;
        md_D = 1'b0;
        @(negedge clk);

        mtWrite(1'b1, 1'b0, 32'h11);
        chk("mthi hi", hi, 32'h11);
        chk("mthi lo untouched", lo, 32'h0);
        mtWrite(1'b1, 1'b1, 32'h22);
        chk("mthi+mtlo hi", hi, 32'h22);
        chk("mthi+mtlo lo", lo, 32'h22);

        startOp(MD_MULT, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, "mult -1*2");
        waitIdle();
        startOp(MD_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5, "multu");
        waitIdle();
        startOp(MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div -7/2");
        waitIdle();
        startOp(MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5, "back-to-back multu");
        waitIdle();
        startOp(MD_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10, "div 7/-2");
        waitIdle();
        startOp(MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 10, "divu 7/2");
        waitIdle();
        startOp(MD_DIVU, 32'd5, 32'd0, 32'd1, 32'd3, 10, "divu by zero");
        waitIdle();

        start = 1'b1; op = MD_DIVU; srcA = 32'd9; srcB = 32'd4;
        mthi = 1'b1; wdata = 32'hDEAD;
        pushExp(32'd1, 32'd2, 10, "divu with mthi");
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        chk("start beats mthi", hi, 32'd1);
        waitIdle();

        md_D = 1'b1;
        start = 1'b1; op = MD_MULT; srcA = 32'd3; srcB = 32'hFFFFFFFC;
        pushExp(32'hFFFFFFFF, 32'hFFFFFFF4, 5, "mult 3*-4 stalled");
        #1 chk("stall in start cycle", stall_md, 1);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 chk($sformatf("stall busy cycle %0d", i + 1), stall_md, 1);
            if (i == 3) chk("mthi while busy ignored", hi, 32'd1);
            mthi = (i == 2);
            wdata = 32'h12345678;
            @(negedge clk);
        end
        mthi = 1'b0;
        #1 chk("stall after busy", stall_md, 0);
        md_D = 1'b0;
        @(negedge clk);

        startOp(MD_DIV, 32'd100, 32'd7, 32'd0, 32'd0, 3, "div aborted by reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("busy after reset", busy, 0);
        mtWrite(1'b0, 1'b1, 32'hABCD);
        chk("mtlo after reset lo", lo, 32'hABCD);
        chk("mtlo after reset hi", hi, 32'h0);

        repeat (3) @(negedge clk);
        chk("scoreboard drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
